// File: rtl/fir_pkg.sv
// Shared definitions for the Lab3 FIR datapath.
// Holds the output-stage FSM encoding, the filter tap count and the default
// widths used by both the address generator and the MAC/output stage.
package fir_pkg;

  localparam int TAP_NUM        = 11;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_LEN_WIDTH  = 32;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous output buffer for finished FIR results.
// Each entry is {last, data}. The head entry is read straight from the
// storage registers, so it stays stable until popped.
// Ports:
//   clk, rst          clock, synchronous active-high reset (pointers/count only)
//   push, push_data,
//   push_last         write one entry (ignored when full unless popping too)
//   pop               remove the head entry (ignored when empty)
//   head_data,
//   head_last         current head entry (undefined while empty)
//   full, empty       occupancy flags
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_WIDTH,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W:0]    mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign {head_last, head_data} = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage: data only, no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {push_last, push_data};
    end
  end

  // Occupancy control
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_mac_out.sv
// MAC and AXI-Stream output stage of the Lab3 FIR datapath.
// Accumulates tap*sample products under the address generator's control,
// buffers finished results in a small FIFO, streams them out and ends the
// run once the output tagged last has been accepted downstream.
// Ports:
//   axis_clk, axis_rst      clock, synchronous active-high reset
//   ap_start, data_length   start pulse and number of outputs in the run
//   mac_reset, mac_EN       clear / accumulate controls from the generator
//   tap_Do, data_Do         signed coefficient and sample words
//   result_ready            push the current accumulator into the FIFO
//   sm_tready/tvalid/tdata/tlast  AXI-Stream master output
//   fifo_full               back-pressure towards the generator
//   ap_idle, ap_done        run status (ap_done is a one-cycle pulse)
//   overflow                sticky: a push was dropped because the FIFO was full
module fir_mac_out
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int pLEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int pFIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start,
  input  logic [pLEN_WIDTH-1:0]  data_length,
  input  logic                   mac_reset,
  input  logic                   mac_EN,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic [pDATA_WIDTH-1:0] data_Do,
  input  logic                   result_ready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  output logic                   fifo_full,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic                   overflow
);

  fsm_state_t                    state;
  logic [pLEN_WIDTH-1:0]         len_reg;
  logic [pLEN_WIDTH-1:0]         out_cnt;
  logic [pLEN_WIDTH-1:0]         push_idx;
  logic signed [pDATA_WIDTH-1:0] acc;
  logic signed [pDATA_WIDTH-1:0] product;

  logic                          in_run;
  logic                          pop;
  logic                          push_req;
  logic                          push_ok;
  logic                          push_last;
  logic                          last_hs;
  logic                          fifo_empty;
  logic [pDATA_WIDTH-1:0]        head_data;
  logic                          head_last;

  // Products wrap to the accumulator width; no saturation anywhere.
  function automatic logic signed [pDATA_WIDTH-1:0] wrap_product(
    input logic signed [pDATA_WIDTH-1:0] a,
    input logic signed [pDATA_WIDTH-1:0] b
  );
    logic signed [2*pDATA_WIDTH-1:0] full_p;
    full_p = a * b;
    return full_p[pDATA_WIDTH-1:0];
  endfunction

  assign product = wrap_product($signed(tap_Do), $signed(data_Do));

  assign in_run   = (state == ST_RUN);
  assign pop      = sm_tvalid && sm_tready;
  assign push_req = result_ready && in_run;
  assign push_ok  = push_req && (!fifo_full || pop);
  // A zero-length run never tags an entry, so it can only be left by reset.
  assign push_last = (len_reg != '0) && (push_idx == len_reg - pLEN_WIDTH'(1));
  assign last_hs   = pop && sm_tlast && in_run;

  // Accumulator: the push captures acc before this edge's update
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      acc <= '0;
    end else if (mac_reset) begin
      acc <= '0;
    end else if (mac_EN) begin
      acc <= acc + product;
    end
  end

  // Output buffer
  fir_out_fifo #(
    .DATA_W (pDATA_WIDTH),
    .DEPTH  (pFIFO_DEPTH)
  ) u_fifo (
    .clk       (axis_clk),
    .rst       (axis_rst),
    .push      (push_ok),
    .push_data (acc),
    .push_last (push_last),
    .pop       (pop),
    .head_data (head_data),
    .head_last (head_last),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Masked while empty so the bus idles at zero rather than stale storage.
  assign sm_tvalid = !fifo_empty;
  assign sm_tdata  = fifo_empty ? '0 : head_data;
  assign sm_tlast  = !fifo_empty && head_last;

  // Run control
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state    <= ST_IDLE;
      len_reg  <= '0;
      out_cnt  <= '0;
      push_idx <= '0;
      overflow <= 1'b0;
      ap_idle  <= 1'b1;
      ap_done  <= 1'b0;
    end else begin
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (ap_start) begin
            state    <= ST_RUN;
            len_reg  <= data_length;
            out_cnt  <= '0;
            push_idx <= '0;
            ap_idle  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (push_ok) begin
            push_idx <= push_idx + pLEN_WIDTH'(1);
          end
          if (pop) begin
            out_cnt <= out_cnt + pLEN_WIDTH'(1);
          end
          if (last_hs) begin
            state   <= ST_DONE;
            ap_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
        end
      endcase
    end
  end

  // out_cnt has no port of its own; it is kept for hierarchical debug probes.
  logic cnt_unused;
  assign cnt_unused = ^out_cnt;

endmodule

// File: tb/tb_fir_mac_out.sv
// Testbench for fir_mac_out: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_fir_mac_out;

  localparam int DW    = 32;
  localparam int LW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ap_start;
  logic [LW-1:0] data_length;
  logic          mac_reset;
  logic          mac_en;
  logic [DW-1:0] tap;
  logic [DW-1:0] dat;
  logic          result_ready;
  logic          sm_tready;
  logic          sm_tvalid;
  logic [DW-1:0] sm_tdata;
  logic          sm_tlast;
  logic          fifo_full;
  logic          ap_idle;
  logic          ap_done;
  logic          overflow;

  fir_mac_out #(
    .pDATA_WIDTH (DW),
    .pLEN_WIDTH  (LW),
    .pFIFO_DEPTH (DEPTH)
  ) dut (
    .axis_clk     (clk),
    .axis_rst     (rst),
    .ap_start     (ap_start),
    .data_length  (data_length),
    .mac_reset    (mac_reset),
    .mac_EN       (mac_en),
    .tap_Do       (tap),
    .data_Do      (dat),
    .result_ready (result_ready),
    .sm_tready    (sm_tready),
    .sm_tvalid    (sm_tvalid),
    .sm_tdata     (sm_tdata),
    .sm_tlast     (sm_tlast),
    .fifo_full    (fifo_full),
    .ap_idle      (ap_idle),
    .ap_done      (ap_done),
    .overflow     (overflow)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  // Reference model: output buffer as a queue, run state as three phases.
  typedef struct {
    bit          last;
    logic [31:0] data;
  } ent_t;
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;

  ent_t        q[$];
  mphase_t     m_st     = M_IDLE;
  logic [31:0] m_acc    = '0;
  logic [31:0] m_len    = '0;
  logic [31:0] m_pushes = '0;
  logic [31:0] m_cnt    = '0;
  bit          m_ovf    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied,
  // clock the DUT, then compare every observable output.
  task automatic cyc();
    bit pop, push_req, push_ok, hs_last, tag_last;
    if (rst) begin
      q.delete();
      m_st = M_IDLE; m_acc = '0; m_len = '0; m_pushes = '0; m_cnt = '0; m_ovf = 1'b0;
    end else begin
      pop      = (q.size() != 0) && sm_tready;
      hs_last  = pop && q[0].last && (m_st == M_RUN);
      push_req = result_ready && (m_st == M_RUN);
      push_ok  = push_req && ((q.size() < DEPTH) || pop);
      tag_last = (m_len != 0) && (m_pushes == m_len - 32'd1);
      if (pop) void'(q.pop_front());
      if (push_ok) begin
        q.push_back('{tag_last, m_acc});
        m_pushes = m_pushes + 32'd1;
      end else if (push_req) begin
        m_ovf = 1'b1;
      end
      if (pop && m_st == M_RUN) m_cnt = m_cnt + 32'd1;
      if (mac_reset) m_acc = '0;
      else if (mac_en) m_acc = m_acc + tap * dat;
      case (m_st)
        M_IDLE: if (ap_start) begin
          m_st = M_RUN; m_len = data_length; m_cnt = '0; m_pushes = '0;
        end
        M_RUN:  if (hs_last) m_st = M_DONE;
        default: m_st = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    if (ap_done === 1'b1) done_cnt++;
    chk("tvalid",   sm_tvalid, (q.size() != 0));
    chk("tdata",    sm_tdata,  (q.size() != 0) ? q[0].data : 32'd0);
    chk("tlast",    sm_tlast,  (q.size() != 0) ? q[0].last : 1'b0);
    chk("fifofull", fifo_full, (q.size() == DEPTH));
    chk("ap_idle",  ap_idle,   (m_st == M_IDLE));
    chk("ap_done",  ap_done,   (m_st == M_DONE));
    chk("overflow", overflow,  m_ovf);
    chk("out_cnt",  dut.out_cnt, m_cnt);
  endtask

  // Make acc equal v, then push it.
  task automatic load_push(input logic [31:0] v);
    mac_reset = 1'b1; cyc(); mac_reset = 1'b0;
    mac_en = 1'b1; tap = v; dat = 32'd1; cyc(); mac_en = 1'b0;
    result_ready = 1'b1; cyc(); result_ready = 1'b0;
  endtask

  int done_before;

  initial begin
    rst = 1'b1; ap_start = 1'b0; data_length = '0; mac_reset = 1'b0; mac_en = 1'b0;
    tap = '0; dat = '0; result_ready = 1'b0; sm_tready = 1'b0;
    cyc();
    chk("rst_tvalid", sm_tvalid, 1'b0);
    chk("rst_tdata",  sm_tdata,  32'd0);
    chk("rst_idle",   ap_idle,   1'b1);
    chk("rst_done",   ap_done,   1'b0);
    chk("rst_full",   fifo_full, 1'b0);
    chk("rst_ovf",    overflow,  1'b0);
    rst = 1'b0;

    // Basic run: sum of 1..11
    data_length = 32'd1; ap_start = 1'b1; cyc(); ap_start = 1'b0;
    mac_reset = 1'b1; cyc(); mac_reset = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      mac_en = 1'b1; tap = i; dat = 32'd1; cyc();
    end
    mac_en = 1'b0;
    sm_tready = 1'b1; result_ready = 1'b1; cyc(); result_ready = 1'b0;
    chk("basic_tvalid", sm_tvalid, 1'b1);
    chk("basic_tdata",  sm_tdata,  32'd66);
    chk("basic_tlast",  sm_tlast,  1'b1);
    cyc();
    chk("basic_done",   ap_done,   1'b1);
    cyc();
    chk("basic_idle",   ap_idle,   1'b1);
    chk("basic_done0",  ap_done,   1'b0);

    // Signed accumulation: 3 * (-2 * 3)
    data_length = 32'd1; ap_start = 1'b1; mac_reset = 1'b1; cyc();
    ap_start = 1'b0; mac_reset = 1'b0;
    mac_en = 1'b1; tap = 32'hFFFF_FFFE; dat = 32'd3;
    repeat (3) cyc();
    mac_en = 1'b0;
    result_ready = 1'b1; cyc(); result_ready = 1'b0;
    chk("signed_tdata", sm_tdata, 32'hFFFF_FFEE);
    repeat (2) cyc();

    // Backpressure and overflow
    sm_tready = 1'b0; data_length = 32'd3; ap_start = 1'b1; cyc(); ap_start = 1'b0;
    load_push(32'd5);
    chk("bp_full1", fifo_full, 1'b0);
    load_push(32'd6);
    chk("bp_full2", fifo_full, 1'b1);
    chk("bp_ovf0",  overflow,  1'b0);
    load_push(32'd7);
    chk("bp_ovf1",  overflow,  1'b1);
    chk("bp_head",  sm_tdata,  32'd5);
    chk("bp_tlast5", sm_tlast, 1'b0);
    repeat (3) begin
      cyc();
      chk("bp_hold", sm_tdata, 32'd5);
    end
    sm_tready = 1'b1; cyc();
    chk("bp_second", sm_tdata, 32'd6);
    chk("bp_tlast6", sm_tlast, 1'b0);
    cyc();
    chk("bp_drain", sm_tvalid, 1'b0);
    load_push(32'd7);
    chk("bp_last_data", sm_tdata, 32'd7);
    chk("bp_last_tag",  sm_tlast, 1'b1);
    cyc();
    chk("bp_done", ap_done, 1'b1);
    cyc();

    // Run with tlast only on the final output
    done_before = done_cnt;
    data_length = 32'd3; ap_start = 1'b1; cyc(); ap_start = 1'b0;
    load_push(32'd5); chk("run_tlast5", sm_tlast, 1'b0);
    load_push(32'd6); chk("run_tlast6", sm_tlast, 1'b0);
    chk("run_nodone", done_cnt - done_before, 32'd0);
    load_push(32'd7); chk("run_tlast7", sm_tlast, 1'b1);
    cyc(); cyc();
    chk("run_done_once", done_cnt - done_before, 32'd1);

    // Priority and same-cycle push/accumulate
    data_length = 32'd3; ap_start = 1'b1; cyc(); ap_start = 1'b0;
    mac_reset = 1'b1; cyc(); mac_reset = 1'b0;
    mac_en = 1'b1; tap = 32'd9; dat = 32'd1; cyc();
    mac_reset = 1'b1; cyc(); mac_reset = 1'b0; mac_en = 1'b0;
    result_ready = 1'b1; cyc(); result_ready = 1'b0;
    chk("prio_zero", sm_tdata, 32'd0);
    chk("prio_valid", sm_tvalid, 1'b1);
    mac_reset = 1'b1; cyc(); mac_reset = 1'b0;
    mac_en = 1'b1; tap = 32'd10; cyc();
    result_ready = 1'b1; tap = 32'd4; cyc(); mac_en = 1'b0;
    chk("simul_push", sm_tdata, 32'd10);
    cyc(); result_ready = 1'b0;
    chk("simul_acc",  sm_tdata, 32'd14);
    chk("simul_last", sm_tlast, 1'b1);
    cyc(); cyc();

    // Reset in the middle of a run
    sm_tready = 1'b0; data_length = 32'd5; ap_start = 1'b1; cyc(); ap_start = 1'b0;
    load_push(32'd1); load_push(32'd2); load_push(32'd3);
    chk("rm_ovf_pre",  overflow,  1'b1);
    chk("rm_full_pre", fifo_full, 1'b1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rm_tvalid", sm_tvalid, 1'b0);
    chk("rm_full",   fifo_full, 1'b0);
    chk("rm_ovf",    overflow,  1'b0);
    chk("rm_idle",   ap_idle,   1'b1);
    result_ready = 1'b1; repeat (3) cyc(); result_ready = 1'b0;
    chk("rm_ignored", sm_tvalid, 1'b0);
    chk("rm_ovf_idle", overflow, 1'b0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      ap_start     = ($urandom_range(0, 19) == 0);
      data_length  = $urandom_range(0, 4);
      mac_reset    = ($urandom_range(0, 9) == 0);
      mac_en       = $urandom_range(0, 1);
      tap          = $urandom;
      dat          = $urandom;
      result_ready = ($urandom_range(0, 4) == 0);
      sm_tready    = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
